// File: rtl/sram_burst_client.sv
// Requester-side client for the SRAM controller burst port: FIFO-buffered write stream
// plus a sequential read job with RD_LAT realignment. Define SRAM_BURST_WRAP_EN for a circular write window.
module sram_burst_client #(
   parameter int AW      = 18,
   parameter int DW      = 16,
   parameter int FIFO_LG = 4,
   parameter int RD_LAT  = 3,
   parameter int WR_WIN  = 1024
) (
   input  logic          Clock,
   input  logic          nReset,
   input  logic          WrStart,
   input  logic [AW-1:0] WrBase,
   input  logic          WrValid,
   input  logic [DW-1:0] WrData,
   output logic          WrReady,
   input  logic          RdStart,
   input  logic [AW-1:0] RdBase,
   input  logic [AW-1:0] RdLen,
   output logic          RdBusy,
   output logic          RdOutValid,
   output logic [DW-1:0] RdOutData,
   output logic          RdDone,
   output logic          ReqBurstWrite,
   output logic [AW-1:0] WrAddrBWrite,
   output logic [DW-1:0] DataBWrite,
   input  logic          AValidBWrite,
   output logic [AW-1:0] RdAddrBRead,
   input  logic          AValidBRead,
   input  logic [DW-1:0] Q
);

   localparam int Depth = 1 << FIFO_LG;
   localparam logic [0:0] Idle  = 1'b0;
   localparam logic [0:0] Issue = 1'b1;

`ifdef SRAM_BURST_WRAP_EN
   localparam logic WrapEn = 1'b1;
`else
   localparam logic WrapEn = 1'b0;
`endif

   // ---------------- write FIFO ----------------
   logic [DW-1:0]      mem [Depth];
   logic [FIFO_LG-1:0] wrPtr, rdPtr;
   logic [FIFO_LG:0]   count, countNext;
   logic               push, pop;

   assign WrReady = count < (FIFO_LG+1)'(Depth);
   assign push    = WrValid & WrReady;
   assign pop     = AValidBWrite & ReqBurstWrite;

   // NOTE: storage is not reset; the head is gated by ReqBurstWrite so stale words never reach the port.
   assign DataBWrite = ReqBurstWrite ? mem[rdPtr] : '0;

   always_ff @(posedge Clock) begin
      if (push) mem[wrPtr] <= WrData;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      countNext = count;
      if (push && !pop)      countNext = count + (FIFO_LG+1)'(1);
      else if (pop && !push) countNext = count - (FIFO_LG+1)'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         wrPtr         <= '0;
         rdPtr         <= '0;
         count         <= '0;
         ReqBurstWrite <= 1'b0;
      end else begin
         if (push) wrPtr <= wrPtr + FIFO_LG'(1);
         if (pop)  rdPtr <= rdPtr + FIFO_LG'(1);
         count         <= countNext;
         ReqBurstWrite <= countNext != '0;
      end
   end

   // ---------------- write address ----------------
   logic [AW-1:0] wrAddr, winBase, winLast, wrAddrInc;

   assign WrAddrBWrite = wrAddr;

   always_comb begin
      winLast   = winBase + AW'(WR_WIN - 1);
      wrAddrInc = wrAddr + AW'(1);
      if (WrapEn && wrAddr == winLast) wrAddrInc = winBase;
   end

   // A new base is only taken between bursts, so words already queued keep their addresses.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         wrAddr  <= '0;
         winBase <= '0;
      end else if (WrStart && count == '0) begin
         wrAddr  <= WrBase;
         winBase <= WrBase;
      end else if (pop) begin
         wrAddr  <= wrAddrInc;
      end
   end

   // ---------------- read job ----------------
   logic [0:0]        state;
   logic [AW-1:0]     rdAddr, rdRemain;
   logic [RD_LAT-1:0] dly;
   logic              rdGrant, rdAccept, lastOut;

   assign RdAddrBRead = rdAddr;
   assign rdGrant     = AValidBRead & (state == Issue);
   assign rdAccept    = RdStart & ~RdBusy;
   // Once issuing is over, an output beat with nothing left in the delay line is the final word.
   assign lastOut     = RdBusy & RdOutValid & (state == Idle) & (dly == '0);

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state      <= Idle;
         rdAddr     <= '0;
         rdRemain   <= '0;
         dly        <= '0;
         RdBusy     <= 1'b0;
         RdOutValid <= 1'b0;
         RdOutData  <= '0;
         RdDone     <= 1'b0;
      end else begin
         dly        <= {dly[RD_LAT-2:0], rdGrant};
         RdOutValid <= dly[RD_LAT-1];
         if (dly[RD_LAT-1]) RdOutData <= Q;
         RdDone     <= lastOut | (rdAccept & (RdLen == '0));
         if (rdAccept && RdLen != '0) begin
            RdBusy   <= 1'b1;
            state    <= Issue;
            rdAddr   <= RdBase;
            rdRemain <= RdLen;
         end else begin
            if (lastOut) RdBusy <= 1'b0;
            if (rdGrant) begin
               rdAddr   <= rdAddr + AW'(1);
               rdRemain <= rdRemain - AW'(1);
               if (rdRemain == AW'(1)) state <= Idle;
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_burst_client.sv
// Self-checking bench for sram_burst_client: directed plus randomized stimulus against
// a transaction-level model (word queue, address counters, per-cycle read return tables).
module tb_sram_burst_client;

   localparam int AW = 18, DW = 16, FIFO_LG = 4, RD_LAT = 3, WIN = 4, DEPTH = 16;

   logic          Clock = 1'b0, nReset = 1'b0;
   logic          WrStart = 1'b0, WrValid = 1'b0, RdStart = 1'b0;
   logic [AW-1:0] WrBase = '0, RdBase = '0, RdLen = '0;
   logic [DW-1:0] WrData = '0, Q = '0;
   logic          AValidBWrite = 1'b0, AValidBRead = 1'b0;
   logic          WrReady, RdBusy, RdOutValid, RdDone, ReqBurstWrite;
   logic [DW-1:0] RdOutData, DataBWrite;
   logic [AW-1:0] WrAddrBWrite, RdAddrBRead;

   sram_burst_client #(.AW(AW), .DW(DW), .FIFO_LG(FIFO_LG), .RD_LAT(RD_LAT), .WR_WIN(WIN)) dut (
      .Clock(Clock), .nReset(nReset),
      .WrStart(WrStart), .WrBase(WrBase), .WrValid(WrValid), .WrData(WrData), .WrReady(WrReady),
      .RdStart(RdStart), .RdBase(RdBase), .RdLen(RdLen), .RdBusy(RdBusy),
      .RdOutValid(RdOutValid), .RdOutData(RdOutData), .RdDone(RdDone),
      .ReqBurstWrite(ReqBurstWrite), .WrAddrBWrite(WrAddrBWrite), .DataBWrite(DataBWrite),
      .AValidBWrite(AValidBWrite), .RdAddrBRead(RdAddrBRead), .AValidBRead(AValidBRead), .Q(Q)
   );

   always #5 Clock = ~Clock;

   int cyc = 0, nChecks = 0, nPass = 0;

   // reference model state
   logic [DW-1:0] fifoQ[$];
   logic [AW-1:0] mWrAddr = '0, mWinBase = '0, mRdAddr = '0;
   int            mRemain = 0;
   logic          mBusy = 1'b0;
   int            doneCyc = -1;
   logic [DW-1:0] qTab [int];
   logic [DW-1:0] outTab [int];

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return DW'(a) ^ DW'(a >> 5) ^ 16'h5A3C;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      nChecks++;
      assert (obs === expd) nPass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
   endtask

   task automatic clearInputs();
      WrStart = 1'b0; WrValid = 1'b0; RdStart = 1'b0;
      AValidBWrite = 1'b0; AValidBRead = 1'b0;
   endtask

   // Apply this cycle's inputs to the model, advance one clock, then compare.
   task automatic tick();
      logic pushOk, popOk;
      popOk  = AValidBWrite && fifoQ.size() != 0;
      pushOk = WrValid && fifoQ.size() < DEPTH;
      if (WrStart && fifoQ.size() == 0) begin
         mWrAddr  = WrBase;
         mWinBase = WrBase;
      end
      if (popOk) begin
         void'(fifoQ.pop_front());
`ifdef SRAM_BURST_WRAP_EN
         mWrAddr = mWinBase + AW'((int'(AW'(mWrAddr - mWinBase)) + 1) % WIN);
`else
         mWrAddr = mWrAddr + AW'(1);
`endif
      end
      if (pushOk) fifoQ.push_back(WrData);

      if (AValidBRead && mRemain > 0) begin
         qTab[cyc + RD_LAT]       = pat(mRdAddr);
         outTab[cyc + RD_LAT + 1] = pat(mRdAddr);
         mRdAddr = mRdAddr + AW'(1);
         mRemain--;
         if (mRemain == 0) doneCyc = cyc + RD_LAT + 2;
      end
      if (RdStart && !mBusy) begin
         if (RdLen == '0) doneCyc = cyc + 1;
         else begin
            mBusy   = 1'b1;
            mRdAddr = RdBase;
            mRemain = int'(RdLen);
         end
      end

      @(posedge Clock);
      #1;
      cyc++;
      clearInputs();
      if (cyc == doneCyc) mBusy = 1'b0;
      Q = qTab.exists(cyc) ? qTab[cyc] : DW'($urandom);

      check("WrReady", WrReady, fifoQ.size() < DEPTH);
      check("ReqBurstWrite", ReqBurstWrite, fifoQ.size() != 0);
      check("WrAddrBWrite", WrAddrBWrite, mWrAddr);
      if (fifoQ.size() != 0) check("DataBWrite", DataBWrite, fifoQ[0]);
      check("RdOutValid", RdOutValid, outTab.exists(cyc));
      if (outTab.exists(cyc)) check("RdOutData", RdOutData, outTab[cyc]);
      check("RdDone", RdDone, cyc == doneCyc);
      check("RdBusy", RdBusy, mBusy);
      if (mRemain > 0) check("RdAddrBRead", RdAddrBRead, mRdAddr);
   endtask

   task automatic doReset();
      clearInputs();
      nReset = 1'b0;
      #2;
      check("rst_WrReady", WrReady, 1);
      check("rst_ReqBurstWrite", ReqBurstWrite, 0);
      check("rst_WrAddrBWrite", WrAddrBWrite, 0);
      check("rst_DataBWrite", DataBWrite, 0);
      check("rst_RdBusy", RdBusy, 0);
      check("rst_RdOutValid", RdOutValid, 0);
      check("rst_RdOutData", RdOutData, 0);
      check("rst_RdDone", RdDone, 0);
      check("rst_RdAddrBRead", RdAddrBRead, 0);
      fifoQ.delete(); qTab.delete(); outTab.delete();
      mWrAddr = '0; mWinBase = '0; mRdAddr = '0;
      mRemain = 0; mBusy = 1'b0; doneCyc = -1;
      nReset = 1'b1;
   endtask

   task automatic drainWrites(input int pct);
      for (int i = 0; i < 400 && fifoQ.size() != 0; i++) begin
         AValidBWrite = ($urandom_range(99) < pct);
         tick();
      end
      check("drain_empty", ReqBurstWrite, 0);
   endtask

   task automatic flushReads(input int pct);
      for (int i = 0; i < 400 && mBusy; i++) begin
         AValidBRead = ($urandom_range(99) < pct);
         tick();
      end
      tick();
      check("rd_idle", RdBusy, 0);
   endtask

   initial begin
      logic [AW-1:0] expRd [4];
      logic [AW-1:0] expWrap [6];
      logic [DW-1:0] wrapData [6];
      logic [DW-1:0] w17;

      @(posedge Clock);
      #1;
      doReset();
      tick();

      // four-word burst at 0x00100
      WrStart = 1'b1; WrBase = 18'h00100;
      for (int i = 0; i < 4; i++) begin
         WrValid = 1'b1; WrData = 16'hA001 + DW'(i);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         check("burst_addr", WrAddrBWrite, 18'h00100 + AW'(i));
         check("burst_data", DataBWrite, 16'hA001 + DW'(i));
         AValidBWrite = 1'b1;
         tick();
      end
      check("burst_req_drop", ReqBurstWrite, 0);

      // fill to full, 17th word held off until the first grant
      WrStart = 1'b1; WrBase = AW'($urandom);
      for (int i = 0; i < DEPTH; i++) begin
         WrValid = 1'b1; WrData = DW'($urandom);
         tick();
      end
      check("full_WrReady", WrReady, 0);
      w17 = DW'($urandom);
      WrValid = 1'b1; WrData = w17;
      tick();
      check("held_WrReady", WrReady, 0);
      WrValid = 1'b1; WrData = w17; AValidBWrite = 1'b1;
      tick();
      check("pop_WrReady", WrReady, 1);
      WrValid = 1'b1; WrData = w17;
      tick();
      for (int i = 0; i < 200 && fifoQ.size() != 0; i++) begin
         if (fifoQ.size() == 1) check("w17_head", DataBWrite, w17);
         AValidBWrite = ($urandom_range(99) < 70);
         tick();
      end
      check("full_drained", ReqBurstWrite, 0);

      // read across the top of the address space
      expRd = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
      RdStart = 1'b1; RdBase = 18'h3FFFE; RdLen = 18'd4;
      tick();
      for (int i = 0; i < 4; i++) begin
         check("rd_addr", RdAddrBRead, expRd[i]);
         AValidBRead = 1'b1;
         tick();
      end
      flushReads(100);

      // gapped grants; a second start while busy is ignored
      RdStart = 1'b1; RdBase = AW'($urandom); RdLen = 18'd2;
      tick();
      AValidBRead = 1'b1;
      tick();
      RdStart = 1'b1; RdBase = AW'($urandom); RdLen = 18'd5;
      tick();
      check("gap_busy", RdBusy, 1);
      tick();
      AValidBRead = 1'b1;
      tick();
      flushReads(100);

      // zero-length job
      RdStart = 1'b1; RdBase = AW'($urandom); RdLen = '0;
      tick();
      check("zero_done", RdDone, 1);
      check("zero_busy", RdBusy, 0);
      tick();

      // write window (wraps only when SRAM_BURST_WRAP_EN is defined)
`ifdef SRAM_BURST_WRAP_EN
      expWrap = '{18'h10, 18'h11, 18'h12, 18'h13, 18'h10, 18'h11};
`else
      expWrap = '{18'h10, 18'h11, 18'h12, 18'h13, 18'h14, 18'h15};
`endif
      WrStart = 1'b1; WrBase = 18'h00010;
      for (int i = 0; i < 6; i++) begin
         wrapData[i] = DW'($urandom);
         WrValid = 1'b1; WrData = wrapData[i];
         tick();
      end
      for (int i = 0; i < 6; i++) begin
         check("win_addr", WrAddrBWrite, expWrap[i]);
         check("win_data", DataBWrite, wrapData[i]);
         AValidBWrite = 1'b1;
         tick();
      end

      // randomized write traffic with stray WrStart and idle read grants
      for (int i = 0; i < 300; i++) begin
         WrValid = 1'($urandom_range(1));
         WrData = DW'($urandom);
         AValidBWrite = ($urandom_range(99) < 45);
         WrStart = ($urandom_range(9) == 0);
         WrBase = AW'($urandom);
         AValidBRead = ($urandom_range(3) == 0);
         tick();
      end
      drainWrites(60);

      // randomized read jobs
      for (int j = 0; j < 8; j++) begin
         RdStart = 1'b1; RdBase = AW'($urandom); RdLen = AW'($urandom_range(6, 1));
         tick();
         flushReads(55);
      end

      // reset mid-burst: 3 words buffered, 2 reads in flight
      WrStart = 1'b1; WrBase = 18'h00200;
      for (int i = 0; i < 3; i++) begin
         WrValid = 1'b1; WrData = DW'($urandom);
         if (i == 2) begin RdStart = 1'b1; RdBase = 18'h00050; RdLen = 18'd4; end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         AValidBRead = 1'b1;
         tick();
      end
      doReset();
      for (int i = 0; i < 8; i++) tick();

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
